// File: rtl/parking_lot_occupancy_pkg.sv
// Types and constants shared by the parking-lot occupancy tracker.
package parking_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_OPEN  = 2'd1,
    S_FULL  = 2'd2
  } lot_state_t;

  localparam int DEFAULT_CAPACITY = 3;

endpackage

// File: rtl/parking_lot_occupancy_sat_counter.sv
// Saturating up-counter: stops at all-ones, synchronous clear has priority over inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                  q <= '0;
    else if (clr)               q <= '0;
    else if (inc && (q != '1))  q <= q + 1'b1;
  end

endmodule

// File: rtl/parking_lot_occupancy.sv
// Occupancy tracker fed by ENTER/EXIT pulses: status flags, peak, totals, sticky errors.
module parking_lot_occupancy
  import parking_pkg::*;
#(
  parameter int CAPACITY = DEFAULT_CAPACITY,
  parameter int TOTAL_W  = 16,
  parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
  input  logic               CLOCK_50,
  input  logic               RSTN,
  input  logic               ENTER,
  input  logic               EXIT,
  input  logic               CLR,
  output logic [CNT_W-1:0]   OCCUPANCY,
  output logic [CNT_W-1:0]   FREE,
  output logic               FULL,
  output logic               EMPTY,
  output logic               FULL_EVT,
  output logic [CNT_W-1:0]   PEAK,
  output logic [TOTAL_W-1:0] TOTAL_ENTRIES,
  output logic [TOTAL_W-1:0] REJECTED,
  output logic               ERR_OVF,
  output logic               ERR_UNF,
  output logic [1:0]         LOT_STATE
);

  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

  logic [CNT_W-1:0] occ_q, occ_d, free_q, peak_q;
  logic             full_q, empty_q, fevt_q, ovf_q, unf_q;
  logic             acc_inc, rej_inc, ovf_set, unf_set;
  lot_state_t       state_q, state_d;

  always_comb begin
    occ_d   = occ_q;
    acc_inc = 1'b0;
    rej_inc = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    // A simultaneous enter/exit is a swap: counted as an entry, occupancy untouched.
    if (ENTER && EXIT) begin
      acc_inc = 1'b1;
    end else if (ENTER) begin
      if (occ_q == CAP) begin
        rej_inc = 1'b1;
        ovf_set = 1'b1;
      end else begin
        occ_d   = occ_q + 1'b1;
        acc_inc = 1'b1;
      end
    end else if (EXIT) begin
      if (occ_q == '0) unf_set = 1'b1;
      else             occ_d   = occ_q - 1'b1;
    end
  end

  always_comb begin
    if (occ_d == '0)       state_d = S_EMPTY;
    else if (occ_d == CAP) state_d = S_FULL;
    else                   state_d = S_OPEN;
  end

  always_ff @(posedge CLOCK_50 or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_EMPTY;
      occ_q   <= '0;
      free_q  <= CAP;
      peak_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      fevt_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (CLR) begin
      state_q <= S_EMPTY;
      occ_q   <= '0;
      free_q  <= CAP;
      peak_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      fevt_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      free_q  <= CAP - occ_d;
      if (occ_d > peak_q) peak_q <= occ_d;
      full_q  <= (state_d == S_FULL);
      empty_q <= (state_d == S_EMPTY);
      fevt_q  <= (state_d == S_FULL) && (state_q != S_FULL);
      if (ovf_set) ovf_q <= 1'b1;
      if (unf_set) unf_q <= 1'b1;
    end
  end

  sat_counter #(.W(TOTAL_W)) u_total (
    .clk(CLOCK_50), .rstn(RSTN), .clr(CLR), .inc(acc_inc), .q(TOTAL_ENTRIES)
  );

  sat_counter #(.W(TOTAL_W)) u_reject (
    .clk(CLOCK_50), .rstn(RSTN), .clr(CLR), .inc(rej_inc), .q(REJECTED)
  );

  assign OCCUPANCY = occ_q;
  assign FREE      = free_q;
  assign FULL      = full_q;
  assign EMPTY     = empty_q;
  assign FULL_EVT  = fevt_q;
  assign PEAK      = peak_q;
  assign ERR_OVF   = ovf_q;
  assign ERR_UNF   = unf_q;
  assign LOT_STATE = state_q;

endmodule

// File: tb/tb_parking_lot_occupancy.sv
// Bench for parking_lot_occupancy: directed vector table, corner sequences, random vs model.
module tb_parking_lot_occupancy;

  localparam int CAP  = 3;
  localparam int TW   = 4;
  localparam int CW   = $clog2(CAP + 1);
  localparam int TMAX = (1 << TW) - 1;

  logic          CLOCK_50 = 1'b0;
  logic          RSTN, ENTER, EXIT, CLR;
  logic [CW-1:0] OCCUPANCY, FREE, PEAK;
  logic          FULL, EMPTY, FULL_EVT, ERR_OVF, ERR_UNF;
  logic [TW-1:0] TOTAL_ENTRIES, REJECTED;
  logic [1:0]    LOT_STATE;

  int n_vec = 0;
  int n_err = 0;

  parking_lot_occupancy #(.CAPACITY(CAP), .TOTAL_W(TW)) dut (
    .CLOCK_50(CLOCK_50), .RSTN(RSTN), .ENTER(ENTER), .EXIT(EXIT), .CLR(CLR),
    .OCCUPANCY(OCCUPANCY), .FREE(FREE), .FULL(FULL), .EMPTY(EMPTY),
    .FULL_EVT(FULL_EVT), .PEAK(PEAK), .TOTAL_ENTRIES(TOTAL_ENTRIES),
    .REJECTED(REJECTED), .ERR_OVF(ERR_OVF), .ERR_UNF(ERR_UNF), .LOT_STATE(LOT_STATE)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int en, ex, clr, idle;
    int occ, fevt, peak, tot, rej, ovf, unf;
  } vec_t;

  vec_t tbl[13];

  // behavioural reference state
  int m_occ, m_peak, m_tot, m_rej, m_ovf, m_unf, m_fevt;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic check_all(input int occ, fevt, peak, tot, rej, ovf, unf);
    chk("occupancy", int'(OCCUPANCY), occ);
    chk("free", int'(FREE), CAP - occ);
    chk("full", int'(FULL), int'(occ == CAP));
    chk("empty", int'(EMPTY), int'(occ == 0));
    chk("full_evt", int'(FULL_EVT), fevt);
    chk("peak", int'(PEAK), peak);
    chk("total", int'(TOTAL_ENTRIES), tot);
    chk("rejected", int'(REJECTED), rej);
    chk("err_ovf", int'(ERR_OVF), ovf);
    chk("err_unf", int'(ERR_UNF), unf);
    chk("lot_state", int'(LOT_STATE), (occ == 0) ? 0 : (occ == CAP) ? 2 : 1);
  endtask

  task automatic step(input int en, ex, clr);
    ENTER = 1'(en);
    EXIT  = 1'(ex);
    CLR   = 1'(clr);
    @(posedge CLOCK_50);
    #1;
    ENTER = 1'b0;
    EXIT  = 1'b0;
    CLR   = 1'b0;
  endtask

  task automatic model_reset();
    m_occ = 0; m_peak = 0; m_tot = 0; m_rej = 0; m_ovf = 0; m_unf = 0; m_fevt = 0;
  endtask

  task automatic model_step(input int en, ex, clr);
    int prev;
    prev = m_occ;
    if (clr != 0) begin
      model_reset();
      return;
    end
    if (en != 0 && ex != 0) begin
      m_tot = (m_tot < TMAX) ? m_tot + 1 : TMAX;
    end else if (en != 0) begin
      if (m_occ < CAP) begin
        m_occ++;
        m_tot = (m_tot < TMAX) ? m_tot + 1 : TMAX;
      end else begin
        m_rej = (m_rej < TMAX) ? m_rej + 1 : TMAX;
        m_ovf = 1;
      end
    end else if (ex != 0) begin
      if (m_occ > 0) m_occ--;
      else           m_unf = 1;
    end
    if (m_occ > m_peak) m_peak = m_occ;
    m_fevt = int'(m_occ == CAP && prev != CAP);
  endtask

  initial begin
    //          en ex clr idle  occ fevt peak tot rej ovf unf
    tbl[0]  = '{1, 0, 0, 0,     1,  0,   1,   1,  0,  0,  0};
    tbl[1]  = '{1, 0, 0, 4,     2,  0,   2,   2,  0,  0,  0};
    tbl[2]  = '{1, 0, 0, 4,     3,  1,   3,   3,  0,  0,  0};
    tbl[3]  = '{0, 0, 0, 0,     3,  0,   3,   3,  0,  0,  0};
    tbl[4]  = '{1, 0, 0, 0,     3,  0,   3,   3,  1,  1,  0};
    tbl[5]  = '{1, 0, 0, 0,     3,  0,   3,   3,  2,  1,  0};
    tbl[6]  = '{1, 1, 0, 0,     3,  0,   3,   4,  2,  1,  0};
    tbl[7]  = '{0, 1, 0, 0,     2,  0,   3,   4,  2,  1,  0};
    tbl[8]  = '{1, 1, 0, 0,     2,  0,   3,   5,  2,  1,  0};
    tbl[9]  = '{1, 0, 1, 0,     0,  0,   0,   0,  0,  0,  0};
    tbl[10] = '{0, 1, 0, 0,     0,  0,   0,   0,  0,  0,  1};
    tbl[11] = '{1, 0, 0, 0,     1,  0,   1,   1,  0,  0,  1};
    tbl[12] = '{0, 1, 0, 0,     0,  0,   1,   1,  0,  0,  1};

    ENTER = 1'b0; EXIT = 1'b0; CLR = 1'b0;
    RSTN  = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #2 RSTN = 1'b1;
    @(posedge CLOCK_50);
    #1;
    check_all(0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      for (int k = 0; k < tbl[i].idle; k++) step(0, 0, 0);
      step(tbl[i].en, tbl[i].ex, tbl[i].clr);
      check_all(tbl[i].occ, tbl[i].fevt, tbl[i].peak, tbl[i].tot,
                tbl[i].rej, tbl[i].ovf, tbl[i].unf);
    end

    // entry counter saturation through alternating pairs
    step(0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0);
      step(0, 1, 0);
    end
    check_all(0, 0, 1, TMAX, 0, 0, 0);

    // asynchronous reset lands between clock edges
    step(1, 0, 0);
    step(1, 0, 0);
    check_all(2, 0, 2, TMAX, 0, 0, 0);
    #3 RSTN = 1'b0;
    #1;
    check_all(0, 0, 0, 0, 0, 0, 0);
    #2 RSTN = 1'b1;
    @(posedge CLOCK_50);
    #1;

    model_reset();
    for (int i = 0; i < 400; i++) begin
      int en, ex, clr;
      en  = int'($urandom_range(0, 1));
      ex  = int'($urandom_range(0, 2) == 0);
      clr = int'($urandom_range(0, 39) == 0);
      step(en, ex, clr);
      model_step(en, ex, clr);
      check_all(m_occ, m_fevt, m_peak, m_tot, m_rej, m_ovf, m_unf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
